router_out_reader: RTL and testbench

- Read-side controller for one router output FIFO.
- Pops bytes from the FIFO and re-frames them into packets: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte.
- Presents the packets to the destination over a valid/ready byte stream and checks parity.
- Asserts soft_reset back to the FIFO when the destination stalls too long.

---
 rtl/router_out_reader.sv | 163 ++++++++++++++++
 tb/tb_router_out_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_reader.sv
// Read-side controller for one router output FIFO: re-frames popped bytes into packets, checks parity,
// streams them over valid/ready and issues soft_reset on a stalled destination. Optional stats: ROUTER_RD_STATS_EN.
module router_out_reader #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty,
  input  logic [7:0]       fifo_dout,
  output logic             read_enb,
  output logic             soft_reset,
  input  logic             dest_ready,
  output logic             pkt_valid,
  output logic [7:0]       pkt_data,
  output logic             pkt_sop,
  output logic             pkt_eop,
  output logic [1:0]       pkt_addr,
  output logic             parity_err,
  output logic [1:0]       dbg_state
`ifdef ROUTER_RD_STATS_EN
  ,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  // Handshake: a byte moves to the destination on every rising edge where pkt_valid && dest_ready;
  // pkt_valid never drops and pkt_data never changes until that happens (except on rst/soft_reset).

  if (TIMEOUT < 2 || TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("router_out_reader: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PLD = 2'd1,
    S_PAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       perr;
  } entry_t;

  entry_t     hold_q [2];
  entry_t     head;
  entry_t     cap_entry;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       inflight;
  state_t     state;
  logic [5:0] rem;
  logic [7:0] acc;
  logic [7:0] stall_cnt;
  logic [1:0] addr_q;

  logic       pop;
  logic       stall;
  logic       soft_reset_next;
  logic [2:0] slots;

  assign head            = hold_q[rd_ptr];
  assign pkt_valid       = (count != 2'd0);
  assign pop             = pkt_valid && dest_ready;
  assign stall           = pkt_valid && !dest_ready;
  assign soft_reset_next = stall && (stall_cnt == 8'(TIMEOUT - 1));

  // Occupancy the buffer will have once this cycle's pop and pending capture settle.
  assign slots    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign read_enb = !rst && !empty && !soft_reset_next && !soft_reset && (slots < 3'd2);

  assign pkt_data   = pkt_valid ? head.data : 8'd0;
  assign pkt_sop    = pkt_valid && head.sop;
  assign pkt_eop    = pkt_valid && head.eop;
  assign parity_err = pkt_valid && head.eop && head.perr;
  assign pkt_addr   = (pkt_valid && head.sop) ? head.data[1:0] : addr_q;
  assign dbg_state  = state;

  always_comb begin
    cap_entry      = '0;
    cap_entry.data = fifo_dout;
    case (state)
      S_HDR:   cap_entry.sop = 1'b1;
      S_PAR: begin
        cap_entry.eop  = 1'b1;
        cap_entry.perr = (fifo_dout != acc);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) hold_q[i] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      inflight   <= 1'b0;
      state      <= S_HDR;
      rem        <= 6'd0;
      acc        <= 8'd0;
      stall_cnt  <= 8'd0;
      addr_q     <= 2'd0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= soft_reset_next;
      if (pkt_valid && head.sop) addr_q <= head.data[1:0];
      if (soft_reset_next) begin
        // Flush: whatever is buffered or in flight belongs to the packet being discarded.
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        count     <= 2'd0;
        inflight  <= 1'b0;
        state     <= S_HDR;
        stall_cnt <= 8'd0;
      end else begin
        inflight  <= read_enb;
        stall_cnt <= stall ? stall_cnt + 8'd1 : 8'd0;
        count     <= count + {1'b0, inflight} - {1'b0, pop};
        if (pop) rd_ptr <= ~rd_ptr;
        if (inflight) begin
          hold_q[wr_ptr] <= cap_entry;
          wr_ptr         <= ~wr_ptr;
          case (state)
            S_HDR: begin
              acc <= fifo_dout;
              if (fifo_dout[7:2] == 6'd0) begin
                state <= S_PAR;
              end else begin
                rem   <= fifo_dout[7:2];
                state <= S_PLD;
              end
            end
            S_PLD: begin
              acc <= acc ^ fifo_dout;
              rem <= rem - 6'd1;
              if (rem == 6'd1) state <= S_PAR;
            end
            default: state <= S_HDR;
          endcase
        end
      end
    end
  end

`ifdef ROUTER_RD_STATS_EN
  // Statistics survive soft_reset so a flushing destination is still visible in the totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (pop && head.eop) begin
      if (pkt_count != '1) pkt_count <= pkt_count + 1'b1;
      if (head.perr && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_out_reader.sv
// Self-checking bench for router_out_reader: FIFO model, per-packet expected queue, stall and reset scenarios.
module tb_router_out_reader;
  localparam int TIMEOUT = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty;
  logic [7:0] fifo_dout;
  logic       read_enb;
  logic       soft_reset;
  logic       dest_ready;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_sop;
  logic       pkt_eop;
  logic [1:0] pkt_addr;
  logic       parity_err;
  logic [1:0] dbg_state;
`ifdef ROUTER_RD_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] err_count;
`endif

  router_out_reader #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .empty      (empty),
    .fifo_dout  (fifo_dout),
    .read_enb   (read_enb),
    .soft_reset (soft_reset),
    .dest_ready (dest_ready),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_sop    (pkt_sop),
    .pkt_eop    (pkt_eop),
    .pkt_addr   (pkt_addr),
    .parity_err (parity_err),
    .dbg_state  (dbg_state)
`ifdef ROUTER_RD_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .err_count  (err_count)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Router FIFO model: 1-cycle read latency, cleared by rst or soft_reset.
  logic [7:0] fifo_mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rst || soft_reset) begin
      rd_ptr <= wr_ptr;
    end else if (read_enb) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Scoreboard: each entry is {addr[1:0], perr, eop, sop, data[7:0]}
  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_xfer   = 0;
  int first_cyc, last_cyc;
  int sr_seen  = 0;
  int exp_pkts = 0;
  int exp_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: a packet is header, len payload bytes, then XOR of header and payload.
  task automatic push_pkt(input logic [7:0] hdr, input bit bad);
    logic [7:0] par;
    logic [7:0] b;
    int         len;
    len = int'(hdr[7:2]);
    par = hdr;
    fifo_mem[wr_ptr] = hdr;
    exp_q.push_back({hdr[1:0], 1'b0, 1'b0, 1'b1, hdr});
    wr_ptr++;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      par = par ^ b;
      fifo_mem[wr_ptr] = b;
      exp_q.push_back({hdr[1:0], 1'b0, 1'b0, 1'b0, b});
      wr_ptr++;
    end
    b = bad ? ~par : par;
    fifo_mem[wr_ptr] = b;
    exp_q.push_back({hdr[1:0], bad, 1'b1, 1'b0, b});
    wr_ptr++;
  endtask

  // One clock: observe at negedge, return 1 time unit after the next posedge.
  task automatic cycle();
    logic [12:0] e;
    @(negedge clk);
    cyc++;
    if (soft_reset) sr_seen++;
    if (empty) check("rd_on_empty", read_enb, 1'b0);
    if (pkt_valid && dest_ready) begin
      n_xfer++;
      if (n_xfer == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("extra_xfer", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (e[9]) exp_pkts++;
        if (e[10]) exp_errs++;
        check("xfer", {pkt_addr, parity_err, pkt_eop, pkt_sop, pkt_data}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: toggle every cycle, 2: random (ready 3 of 4 cycles)
  task automatic drain(input int mode);
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      case (mode)
        1:       dest_ready = ~dest_ready;
        2:       dest_ready = ($urandom_range(0, 3) != 0);
        default: dest_ready = 1'b1;
      endcase
      cycle();
      budget--;
    end
    check("drain_timeout", exp_q.size(), 0);
    dest_ready = 1'b1;
    repeat (4) cycle();
  endtask

  // Hold dest_ready low until n stall cycles have been observed; returns soft_reset sightings.
  task automatic stall_for(input int n, output int stalls, output int early_sr);
    int guard;
    stalls   = 0;
    early_sr = 0;
    guard    = 0;
    dest_ready = 1'b0;
    while (stalls < n && guard < 200) begin
      @(negedge clk);
      cyc++;
      guard++;
      if (soft_reset) early_sr++;
      if (pkt_valid && !dest_ready) stalls++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int stalls, early_sr, guard;

    rst        = 1'b1;
    dest_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outs", {read_enb, soft_reset, pkt_valid, pkt_sop, pkt_eop, parity_err, pkt_addr, pkt_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-rate packet, header 0x39 (len 14, addr 01)
    dest_ready = 1'b1;
    n_xfer = 0;
    push_pkt(8'h39, 1'b0);
    drain(0);
    check("t1_count", n_xfer, 16);
    check("t1_span", last_cyc - first_cyc, 15);

    // Corrupted parity, then a clean packet right behind it
    push_pkt(8'h39, 1'b1);
    push_pkt(8'($urandom_range(0, 255)), 1'b0);
    drain(0);

    // Zero-length packet
    n_xfer = 0;
    push_pkt(8'h02, 1'b0);
    drain(0);
    check("t3_count", n_xfer, 2);

    // Back-to-back packets with dest_ready toggling every cycle
    push_pkt(8'($urandom_range(0, 255)), 1'b0);
    push_pkt(8'($urandom_range(0, 255)), 1'b0);
    drain(1);

    // Random traffic
    for (int i = 0; i < 10; i++) push_pkt(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    drain(2);

    // Stall watchdog fires at the end of stall cycle TIMEOUT
    push_pkt({6'd5, 2'b11}, 1'b0);
    stall_for(TIMEOUT, stalls, early_sr);
    check("stall_reached", stalls, TIMEOUT);
    check("sr_early", early_sr, 0);
    @(negedge clk);
    check("sr_pulse", soft_reset, 1'b1);
    check("sr_valid_low", pkt_valid, 1'b0);
    check("sr_rd_low", read_enb, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("sr_one_cycle", soft_reset, 1'b0);
    check("sr_flushed", pkt_valid, 1'b0);
    @(posedge clk);
    #1;
    exp_q.delete();

    // Destination recovers in stall cycle TIMEOUT: no soft_reset, packet intact
    push_pkt({6'd5, 2'b10}, 1'b0);
    stall_for(TIMEOUT - 1, stalls, early_sr);
    check("stall29_reached", stalls, TIMEOUT - 1);
    sr_seen = early_sr;
    n_xfer  = 0;
    drain(0);
    check("no_sr", sr_seen, 0);
    check("recover_count", n_xfer, 7);

    // Reset in the middle of the payload
    dest_ready = 1'b1;
    n_xfer = 0;
    push_pkt({6'd20, 2'b01}, 1'b0);
    guard = 0;
    while (n_xfer < 5 && guard < 100) begin
      cycle();
      guard++;
    end
    check("mid_xfers", n_xfer, 5);
    rst = 1'b1;
    exp_q.delete();
    exp_pkts = 0;
    exp_errs = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_outs", {read_enb, soft_reset, pkt_valid, pkt_sop, pkt_eop, parity_err, pkt_addr, pkt_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_pkt(8'($urandom_range(0, 255)), 1'b0);
    push_pkt(8'($urandom_range(0, 255)), 1'b1);
    drain(0);

`ifdef ROUTER_RD_STATS_EN
    check("pkt_count", pkt_count, exp_pkts);
    check("err_count", err_count, exp_errs);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
